// File: rtl/counter_chk_pkg.sv
// Shared encodings for the counter_checker monitor and its event FIFO.
package counter_chk_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] EVT_WRAP     = 2'b01;
    localparam logic [1:0] EVT_MISMATCH = 2'b10;

    typedef enum logic [1:0] {
        SEED  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } chk_state_t;

endpackage

// File: rtl/chk_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only alongside a pop.
module chk_event_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Golden-model monitor for first_counter with wrap/mismatch event FIFO.
// Optional CNT_CHK_TIMESTAMP_EN adds a per-event 16-bit cycle stamp (evt_ts).
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctr_clr,
    input  logic             ctr_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             chk_en,
    input  logic             clear_err,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [WIDTH-1:0] evt_obs,
    output logic [WIDTH-1:0] evt_exp,
`ifdef CNT_CHK_TIMESTAMP_EN
    output logic [15:0]      evt_ts,
`endif
    output logic             err_flag,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] drop_count
);

`ifdef CNT_CHK_TIMESTAMP_EN
    localparam int DW = 2 + 2 * WIDTH + 16;
`else
    localparam int DW = 2 + 2 * WIDTH;
`endif

    chk_state_t       state;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_en;
    logic             prev_clr;
    logic [WIDTH-1:0] exp_cnt;
    logic             mis;
    logic             wrap;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [DW-1:0]    din;
    logic [DW-1:0]    dout;

    always_comb begin
        exp_cnt = prev_cnt;
        if (prev_clr)     exp_cnt = '0;
        else if (prev_en) exp_cnt = prev_cnt + 1'b1;
    end

    assign mis  = chk_en && (state == TRACK) && (count_in != exp_cnt);
    assign wrap = chk_en && (state == TRACK) && !mis && prev_en &&
                  !prev_clr && (&prev_cnt) && (count_in == '0);
    assign push = mis || wrap;
    assign pop  = evt_valid && evt_ready;

`ifdef CNT_CHK_TIMESTAMP_EN
    logic [15:0] cyc;

    // Stamp carries the cycle value that becomes current on the push edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 1'b1;
    end

    assign din = mis ? {EVT_MISMATCH, count_in, exp_cnt, cyc + 16'd1}
                     : {EVT_WRAP, {(2*WIDTH){1'b0}}, cyc + 16'd1};
    assign {evt_type, evt_obs, evt_exp, evt_ts} = dout;
`else
    assign din = mis ? {EVT_MISMATCH, count_in, exp_cnt}
                     : {EVT_WRAP, {(2*WIDTH){1'b0}}};
    assign {evt_type, evt_obs, evt_exp} = dout;
`endif

    assign evt_valid = !empty;

    chk_event_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SEED;
            prev_cnt   <= '0;
            prev_en    <= 1'b0;
            prev_clr   <= 1'b0;
            err_flag   <= 1'b0;
            wrap_count <= '0;
            drop_count <= '0;
        end else begin
            prev_cnt <= count_in;
            prev_en  <= ctr_en;
            prev_clr <= ctr_clr;

            if (mis)            err_flag <= 1'b1;
            else if (clear_err) err_flag <= 1'b0;

            if (wrap) wrap_count <= wrap_count + 1'b1;

            if (push && full && !pop && drop_count != CNT_MAX)
                drop_count <= drop_count + 1'b1;

            unique case (state)
                SEED: begin
                    if (chk_en) state <= TRACK;
                end
                TRACK: begin
                    if (!chk_en)  state <= SEED;
                    else if (mis) state <= FAULT;
                end
                FAULT: begin
                    if (!chk_en)                  state <= SEED;
                    else if (count_in == exp_cnt) state <= TRACK;
                end
                default: state <= SEED;
            endcase
        end
    end

endmodule
